uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among several on-robot message sources (ultrasonic distance reports, status, command acks) using round-robin arbitration. Each accepted request becomes a three-byte frame on the transmitter: header, payload, checksum. Sits between the communication controllers and the UART TX stream interface. Guarantees whole frames are never interleaved.

---
 rtl/comm_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the UART frame arbiter: FSM encoding, frame tag
// and the header/checksum helpers used by both the RTL and its users.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } arb_state_t;

  localparam logic [3:0] FRAME_TAG = 4'hA;
  localparam int         GID_W     = 4;

  function automatic logic [7:0] frame_header(input logic [GID_W-1:0] id);
    return {FRAME_TAG, id};
  endfunction

  function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                input logic [7:0] pay);
    return hdr ^ pay;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/TX bundle between the message sources, the arbiter and the UART.
// slave = arbiter side, master = sources/UART side.
interface uart_tx_arbiter_if
  import comm_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic               busy;
  logic [GID_W-1:0]   grant_id;
  logic               frame_done;

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, busy, grant_id, frame_done
  );

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, busy, grant_id, frame_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N_REQ, wins.
module rr_arbiter
  import comm_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [GID_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rotated;
  int                 win;

  assign req_dbl = {req, req};
  assign any     = |req;

  // NOTE: every output and temporary gets a default before the loops, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rotated = N_REQ'(req_dbl >> ptr);
    win     = 0;
    // Walk downwards so the lowest rotated position, i.e. nearest ptr, wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) win = int'(ptr) + k;
    end
    if (win >= N_REQ) win = win - N_REQ;
    gnt_idx = GID_W'(win);
    gnt     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = any && (win == i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX stream: each accepted request becomes a
// header/payload/checksum frame, never interleaved with another.
module uart_tx_arbiter
  import comm_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic clk,
  input  logic reset,
  uart_tx_arbiter_if.slave bus
);

  arb_state_t       state_q, state_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [GID_W-1:0] gid_q, gid_d;
  logic [7:0]       pay_q, pay_d;
  logic             frame_done_q, frame_done_d;

  logic [N_REQ-1:0] gnt;
  logic [GID_W-1:0] gnt_idx;
  logic             any;
  logic             accept;
  logic [7:0]       sel_data;
  logic [7:0]       hdr;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Gated by reset so a source is never told it was accepted in a cycle
  // whose capture the reset is about to discard.
  assign accept = (state_q == IDLE) && any && !reset;
  assign hdr    = frame_header(gid_q);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_data = bus.req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gid_d        = gid_q;
    pay_d        = pay_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HEADER;
          pay_d   = sel_data;
          gid_d   = gnt_idx;
          ptr_d   = (gnt_idx == GID_W'(N_REQ - 1)) ? '0 : gnt_idx + GID_W'(1);
        end
      end
      HEADER:  if (bus.tx_ready) state_d = PAYLOAD;
      PAYLOAD: if (bus.tx_ready) state_d = CHECK;
      CHECK: begin
        if (bus.tx_ready) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the blocking next-state logic above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gid_q        <= '0;
      pay_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gid_q        <= gid_d;
      pay_q        <= pay_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    unique case (state_q)
      HEADER:  bus.tx_data = hdr;
      PAYLOAD: bus.tx_data = pay_q;
      CHECK:   bus.tx_data = frame_checksum(hdr, pay_q);
      default: bus.tx_data = 8'h00;
    endcase
  end

  assign bus.req_ready  = accept ? gnt : '0;
  assign bus.tx_valid   = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = gid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = '0;
    bus.tx_ready  = 1'b1;
    while (bus.busy && n < 20) begin
      next_cycle();
      n++;
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = 24'($urandom);
    bus.tx_ready  = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_req_ready: got %b required 000", bus.req_ready); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b required 0", bus.tx_valid); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h required 00", bus.tx_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.grant_id !== 4'h0) begin miscompares++; $display("FAIL reset_grant_id: got %h required 0", bus.grant_id); end
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b required 0", bus.frame_done); end
    next_cycle();
    bus.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_data  = 24'h003700;
    sample();
    vectors++; if (bus.req_ready !== 3'b010) begin miscompares++; $display("FAIL single_accept: got %b required 010", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    sample();
    vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL single_hdr_valid: got %b required 1", bus.tx_valid); end
    vectors++; if (bus.tx_data !== 8'hA1) begin miscompares++; $display("FAIL single_hdr: got %h required a1", bus.tx_data); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b required 1", bus.busy); end
    vectors++; if (bus.grant_id !== 4'h1) begin miscompares++; $display("FAIL single_grant_id: got %h required 1", bus.grant_id); end
    next_cycle();
    sample();
    vectors++; if (bus.tx_data !== 8'h37) begin miscompares++; $display("FAIL single_payload: got %h required 37", bus.tx_data); end
    next_cycle();
    sample();
    vectors++; if (bus.tx_data !== 8'h96) begin miscompares++; $display("FAIL single_checksum: got %h required 96", bus.tx_data); end
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL single_done_early: got %b required 0", bus.frame_done); end
    next_cycle();
    sample();
    vectors++; if (bus.frame_done !== 1'b1) begin miscompares++; $display("FAIL single_done: got %b required 1", bus.frame_done); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle_valid: got %b required 0", bus.tx_valid); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL single_idle_data: got %h required 00", bus.tx_data); end
    next_cycle();
    sample();
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b required 0", bus.frame_done); end
    vectors++; if (bus.grant_id !== 4'h1) begin miscompares++; $display("FAIL single_gid_hold: got %h required 1", bus.grant_id); end
    next_cycle();
  endtask

  task automatic test_all_requesting();
    int seen   = 0;
    int last   = -1;
    int exp_id = 0;
    logic [N-1:0] exp_oh;
    do_reset();
    bus.req_valid = 3'b111;
    bus.req_data  = 24'($urandom);
    for (int c = 0; c < 40 && seen < 6; c++) begin
      sample();
      if (bus.req_ready !== 3'b000) begin
        exp_oh = N'(1) << exp_id;
        vectors++; if (bus.req_ready !== exp_oh) begin miscompares++; $display("FAIL all_order[%0d]: got %b required %b", seen, bus.req_ready, exp_oh); end
        if (seen > 0) begin
          vectors++; if (c - last !== 4) begin miscompares++; $display("FAIL all_spacing[%0d]: got %0d cycles required 4", seen, c - last); end
        end
        last   = c;
        seen++;
        exp_id = (exp_id + 1) % N;
      end
      next_cycle();
    end
    vectors++; if (seen !== 6) begin miscompares++; $display("FAIL all_count: got %0d grants required 6", seen); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] pay;
    logic [7:0] got [3];
    int done_at = -1;
    int nx = 0;
    pay = 8'($urandom);
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_data  = {16'h0000, pay};
    sample();
    vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL bp_accept: got %b required 001", bus.req_ready); end
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      next_cycle();
      bus.req_valid = '0;
      bus.tx_ready  = !(c >= 2 && c <= 6);
      sample();
      if (c >= 2 && c <= 6) begin
        vectors++; if (bus.tx_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stall_valid[%0d]: got %b required 1", c, bus.tx_valid); end
        vectors++; if (bus.tx_data !== pay) begin miscompares++; $display("FAIL bp_stall_data[%0d]: got %h required %h", c, bus.tx_data, pay); end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (nx < 3) got[nx] = bus.tx_data;
        nx++;
      end
      if (bus.frame_done) done_at = c;
    end
    vectors++; if (done_at !== 9) begin miscompares++; $display("FAIL bp_done_cycle: got A+%0d required A+9", done_at); end
    vectors++; if (nx !== 3) begin miscompares++; $display("FAIL bp_transfers: got %0d required 3", nx); end
    vectors++; if (got[0] !== 8'hA0) begin miscompares++; $display("FAIL bp_hdr: got %h required a0", got[0]); end
    vectors++; if (got[1] !== pay) begin miscompares++; $display("FAIL bp_payload: got %h required %h", got[1], pay); end
    vectors++; if (got[2] !== (8'hA0 ^ pay)) begin miscompares++; $display("FAIL bp_checksum: got %h required %h", got[2], 8'hA0 ^ pay); end
    bus.tx_ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_mid_frame();
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_data  = 24'($urandom);
    sample();
    vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL mid_accept0: got %b required 001", bus.req_ready); end
    next_cycle();
    bus.req_valid = 3'b100;
    for (int c = 1; c <= 3; c++) begin
      sample();
      vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL mid_blocked[A+%0d]: got %b required 000", c, bus.req_ready); end
      next_cycle();
    end
    sample();
    vectors++; if (bus.req_ready !== 3'b100) begin miscompares++; $display("FAIL mid_accept2: got %b required 100", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    sample();
    vectors++; if (bus.tx_data !== 8'hA2) begin miscompares++; $display("FAIL mid_hdr2: got %h required a2", bus.tx_data); end
    next_cycle();
    drain();
  endtask

  task automatic test_reset_mid_frame();
    int found = 0;
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_data  = 24'($urandom);
    sample();
    vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL rmf_accept: got %b required 001", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.req_valid = 3'b011;
    sample();
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_tx_valid: got %b required 0", bus.tx_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmf_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.frame_done !== 1'b0) begin miscompares++; $display("FAIL rmf_frame_done: got %b required 0", bus.frame_done); end
    vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL rmf_first_grant: got %b required 001", bus.req_ready); end
    next_cycle();
    bus.req_valid = 3'b010;
    for (int c = 0; c < 10 && found == 0; c++) begin
      sample();
      if (bus.req_ready !== 3'b000) begin
        found = 1;
        vectors++; if (bus.req_ready !== 3'b010) begin miscompares++; $display("FAIL rmf_second_grant: got %b required 010", bus.req_ready); end
      end
      next_cycle();
    end
    vectors++; if (found !== 1) begin miscompares++; $display("FAIL rmf_second_timeout: got %0d grants required 1", found); end
    drain();
  endtask

  task automatic test_drop_before_accept();
    int g1 = 0;
    int nx = 0;
    int nd = 0;
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_data  = 24'($urandom);
    sample();
    vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL drop_accept0: got %b required 001", bus.req_ready); end
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      bus.req_valid = (c == 2) ? 3'b010 : 3'b000;
      sample();
      if (bus.req_ready[1]) g1++;
      if (bus.tx_valid && bus.tx_ready) nx++;
      if (bus.frame_done) nd++;
    end
    vectors++; if (g1 !== 0) begin miscompares++; $display("FAIL drop_granted: got %0d grants required 0", g1); end
    vectors++; if (nx !== 3) begin miscompares++; $display("FAIL drop_transfers: got %0d required 3", nx); end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL drop_frames: got %0d required 1", nd); end
    next_cycle();
  endtask

  // Frame-level model: a pending request is held until granted; when the
  // model has no outstanding bytes the first pending source at or after
  // model_ptr wins, and its three frame bytes are queued for the UART.
  task automatic test_random();
    logic [7:0]   expq [$];
    logic [7:0]   pdata [N];
    logic [N-1:0] pending = '0;
    logic [N-1:0] exp_rr;
    logic [7:0]   hdr;
    logic [7:0]   exp_data;
    int model_ptr = 0;
    int last_gid  = 0;
    int win;
    int idx;
    logic exp_done = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) pdata[IW'(i)] = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[IW'(i)] && $urandom_range(0, 3) == 0) begin
          pending[IW'(i)] = 1'b1;
          pdata[IW'(i)]   = 8'($urandom);
        end
        bus.req_data[8*i +: 8] = pdata[IW'(i)];
      end
      bus.req_valid = pending;
      bus.tx_ready  = ($urandom_range(0, 3) != 0);
      sample();
      win    = -1;
      exp_rr = '0;
      if (expq.size() == 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (model_ptr + k) % N;
          if (win < 0 && pending[IW'(idx)]) win = idx;
        end
        if (win >= 0) exp_rr = N'(1) << win;
      end
      exp_data = (expq.size() != 0) ? expq[0] : 8'h00;
      vectors++; if (bus.req_ready !== exp_rr) begin miscompares++; $display("FAIL rnd_req_ready@%0d: got %b required %b", cyc, bus.req_ready, exp_rr); end
      vectors++; if (bus.tx_valid !== (expq.size() != 0)) begin miscompares++; $display("FAIL rnd_tx_valid@%0d: got %b required %b", cyc, bus.tx_valid, expq.size() != 0); end
      vectors++; if (bus.busy !== (expq.size() != 0)) begin miscompares++; $display("FAIL rnd_busy@%0d: got %b required %b", cyc, bus.busy, expq.size() != 0); end
      vectors++; if (bus.tx_data !== exp_data) begin miscompares++; $display("FAIL rnd_tx_data@%0d: got %h required %h", cyc, bus.tx_data, exp_data); end
      vectors++; if (bus.grant_id !== 4'(last_gid)) begin miscompares++; $display("FAIL rnd_grant_id@%0d: got %h required %h", cyc, bus.grant_id, 4'(last_gid)); end
      vectors++; if (bus.frame_done !== exp_done) begin miscompares++; $display("FAIL rnd_frame_done@%0d: got %b required %b", cyc, bus.frame_done, exp_done); end
      exp_done = 1'b0;
      if (win >= 0) begin
        last_gid = win;
        hdr      = {4'hA, 4'(win)};
        expq.push_back(hdr);
        expq.push_back(pdata[IW'(win)]);
        expq.push_back(hdr ^ pdata[IW'(win)]);
        model_ptr = (win + 1) % N;
        pending[IW'(win)] = 1'b0;
      end else if (expq.size() != 0 && bus.tx_ready) begin
        void'(expq.pop_front());
        if (expq.size() == 0) exp_done = 1'b1;
      end
      next_cycle();
    end
    drain();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    test_reset();
    test_single();
    test_all_requesting();
    test_backpressure();
    test_mid_frame();
    test_reset_mid_frame();
    test_drop_before_accept();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
